// File: rtl/module_display_scan_pkg.sv
// Shared types and constants for the 4-digit multiplexed 7-segment display driver.
package display_pkg;

  localparam int NUM_DIGITS = 4;

  // Segment patterns are active-low, ordered {g,f,e,d,c,b,a}.
  localparam logic [6:0] SEG_OFF  = 7'h7F;
  localparam logic [6:0] SEG_DASH = 7'b0111111;

  typedef enum logic {BLANK, DRIVE} scan_state_t;

  typedef logic [3:0] bcd_t;

endpackage

// File: rtl/module_display_scan_if.sv
// Bus between the operand/sum mux and the display scanner, plus scanner debug state.
interface module_display_scan_if;
  import display_pkg::*;

  // load_i is a one-cycle valid with no ready: the scanner accepts every strobe.
  // A strobe on the frame-boundary cycle is committed directly. Any other strobe lands
  // in the pending buffer, and pend_o stays high until the next boundary takes it.
  logic [15:0] data_i;
  logic        load_i;
  logic        pend_o;
  logic [3:0]  an_o;
  logic [6:0]  seg_o;
  logic        frame_o;

  scan_state_t dbg_state;
  logic [1:0]  dbg_idx;

  modport slave (
    input  data_i, load_i,
    output pend_o, an_o, seg_o, frame_o, dbg_state, dbg_idx
  );

  modport master (
    output data_i, load_i,
    input  pend_o, an_o, seg_o, frame_o, dbg_state, dbg_idx
  );

endinterface

// File: rtl/module_display_scan_seg_decode.sv
// BCD nibble to active-low {g,f,e,d,c,b,a} segments; non-decimal nibbles show a dash.
module module_seg_decode
  import display_pkg::*;
(
  input  bcd_t       bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_DASH;
    case (bcd)
      4'd0: seg = 7'b1000000;
      4'd1: seg = 7'b1111001;
      4'd2: seg = 7'b0100100;
      4'd3: seg = 7'b0110000;
      4'd4: seg = 7'b0011001;
      4'd5: seg = 7'b0010010;
      4'd6: seg = 7'b0000010;
      4'd7: seg = 7'b1111000;
      4'd8: seg = 7'b0000000;
      4'd9: seg = 7'b0010000;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/module_display_scan.sv
// Time-multiplexed 4-digit common-anode display scanner with frame-aligned word commit
// and leading-zero suppression.
module module_display_scan
  import display_pkg::*;
#(
  parameter int REFRESH_DIV = 27000,
  parameter bit BLANK_LZ    = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  module_display_scan_if.slave  bus
);

  localparam int PW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);

  scan_state_t   state, state_nxt;
  logic [1:0]    idx, idx_nxt;
  logic [PW-1:0] presc, presc_nxt;
  logic [15:0]   disp, disp_nxt;
  logic [15:0]   pend_buf, pend_buf_nxt;
  logic          pend, pend_nxt;
  logic          boundary;

  logic [3:0]    an_q, an_nxt;
  logic [6:0]    seg_q, seg_nxt;
  logic          frame_q;

  bcd_t          digit;
  logic [6:0]    digit_seg;
  logic          lz_blank;

  assign boundary = (state == BLANK) && (idx == 2'd0);

  // Word commit: a boundary load bypasses the buffer so the new frame shows it at once.
  always_comb begin
    disp_nxt     = disp;
    pend_buf_nxt = pend_buf;
    pend_nxt     = pend;
    if (boundary) begin
      if (bus.load_i)
        disp_nxt = bus.data_i;
      else if (pend)
        disp_nxt = pend_buf;
      pend_nxt = 1'b0;
    end else if (bus.load_i) begin
      pend_buf_nxt = bus.data_i;
      pend_nxt     = 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    presc_nxt = presc;
    case (state)
      BLANK: state_nxt = DRIVE;
      DRIVE: begin
        if (presc == PRESC_LAST) begin
          state_nxt = BLANK;
          presc_nxt = '0;
          idx_nxt   = idx + 2'd1;
        end else begin
          presc_nxt = presc + 1'b1;
        end
      end
      default: state_nxt = BLANK;
    endcase
  end

  // Outputs are computed from next-cycle state so they line up with the state register.
  assign digit = disp_nxt[{idx_nxt, 2'b00} +: 4];

  module_seg_decode u_seg_decode (
    .bcd (digit),
    .seg (digit_seg)
  );

  always_comb begin
    lz_blank = 1'b0;
    if (BLANK_LZ) begin
      case (idx_nxt)
        2'd1:    lz_blank = (disp_nxt[15:4]  == 12'd0);
        2'd2:    lz_blank = (disp_nxt[15:8]  == 8'd0);
        2'd3:    lz_blank = (disp_nxt[15:12] == 4'd0);
        default: lz_blank = 1'b0;
      endcase
    end
  end

  always_comb begin
    an_nxt  = 4'b1111;
    seg_nxt = SEG_OFF;
    if ((state_nxt == DRIVE) && !lz_blank) begin
      an_nxt  = ~(4'b0001 << idx_nxt);
      seg_nxt = digit_seg;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= BLANK;
      idx      <= 2'd0;
      presc    <= '0;
      disp     <= 16'd0;
      pend_buf <= 16'd0;
      pend     <= 1'b0;
      an_q     <= 4'b1111;
      seg_q    <= SEG_OFF;
      frame_q  <= 1'b0;
    end else begin
      state    <= state_nxt;
      idx      <= idx_nxt;
      presc    <= presc_nxt;
      disp     <= disp_nxt;
      pend_buf <= pend_buf_nxt;
      pend     <= pend_nxt;
      an_q     <= an_nxt;
      seg_q    <= seg_nxt;
      frame_q  <= boundary;
    end
  end

  assign bus.pend_o    = pend;
  assign bus.an_o      = an_q;
  assign bus.seg_o     = seg_q;
  assign bus.frame_o   = frame_q;
  assign bus.dbg_state = state;
  assign bus.dbg_idx   = idx;

endmodule

// File: tb/tb_module_display_scan.sv
// Bench for module_display_scan with REFRESH_DIV = 4 (20-cycle frames).
`timescale 1ns/1ps
module tb_module_display_scan;
  import display_pkg::*;

  localparam logic [6:0] G0 = 7'b1000000, G1 = 7'b1111001, G2 = 7'b0100100,
                         G3 = 7'b0110000, G4 = 7'b0011001, G5 = 7'b0010010,
                         G6 = 7'b0000010, G7 = 7'b1111000, G8 = 7'b0000000,
                         G9 = 7'b0010000, GD = 7'b0111111, GX = 7'h7F;
  localparam int FRAME = 20;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #50 clk = ~clk;

  module_display_scan_if bus ();

  module_display_scan #(.REFRESH_DIV(4), .BLANK_LZ(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [15:0] data;
    logic [27:0] segs;  // {digit3, digit2, digit1, digit0}; GX means blanked
  } vec_t;

  vec_t vecs[7];
  logic [11:0] exp_q[$];  // {frame_o, an_o, seg_o} per cycle
  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  int last_frame = 0;
  bit have_last = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    assert ($countones(~bus.an_o) <= 1)
      else $error("an_o has more than one low bit: %b", bus.an_o);
  end

  // Frame period between consecutive frame_o pulses.
  always @(negedge clk) begin
    if (!rst) begin
      have_last = 1'b0;
    end else if (bus.frame_o) begin
      if (have_last) begin
        n_chk++;
        if (cyc - last_frame == FRAME) n_pass++;
        else $display("FAIL frame_period actual=%0d required=%0d", cyc - last_frame, FRAME);
      end
      last_frame = cyc;
      have_last  = 1'b1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%h required=%h at cycle %0d", name, act, exp, cyc);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_an"},    16'(bus.an_o),    16'h000F);
    chk({tag, "_seg"},   16'(bus.seg_o),   16'h007F);
    chk({tag, "_pend"},  16'(bus.pend_o),  16'h0000);
    chk({tag, "_frame"}, 16'(bus.frame_o), 16'h0000);
  endtask

  // Starts on cycle 0 of a frame; checks all 20 cycles against segs and optionally drives
  // up to two loads (position -1 = none). Ends on cycle 0 of the next frame.
  task automatic check_frame(input string tag, input logic [27:0] segs,
                             input int p1, input logic [15:0] d1,
                             input int p2, input logic [15:0] d2);
    logic [11:0] e, got;
    logic [6:0]  s;
    bit ep;
    ep = 1'b0;
    for (int c = 0; c < FRAME; c++) begin
      s = segs[(c / 5) * 7 +: 7];
      if (c % 5 == 4 || s == GX) e = {(c == 0), 4'b1111, GX};
      else                       e = {(c == 0), ~(4'b0001 << (c / 5)), s};
      exp_q.push_back(e);
    end
    for (int c = 0; c < FRAME; c++) begin
      got = {bus.frame_o, bus.an_o, bus.seg_o};
      chk({tag, "_scan"}, 16'(got), 16'(exp_q.pop_front()));
      chk({tag, "_pend"}, 16'(bus.pend_o), 16'(ep));
      if (c == p1) begin
        bus.load_i = 1'b1; bus.data_i = d1;
      end else if (c == p2) begin
        bus.load_i = 1'b1; bus.data_i = d2;
      end else begin
        bus.load_i = 1'b0;
      end
      ep = ep | (bus.load_i && c != FRAME - 1);
      step();
    end
    bus.load_i = 1'b0;
  endtask

  logic [27:0] prev;

  initial begin
    vecs[0] = '{16'h9876, {G9, G8, G7, G6}};
    vecs[1] = '{16'h0123, {GX, G1, G2, G3}};
    vecs[2] = '{16'h0000, {GX, GX, GX, G0}};
    vecs[3] = '{16'h12A4, {G1, G2, GD, G4}};
    vecs[4] = '{16'h0050, {GX, GX, G5, G0}};
    vecs[5] = '{16'h1000, {G1, G0, G0, G0}};
    vecs[6] = '{16'h00F0, {GX, GX, GD, G0}};

    bus.load_i = 1'b0;
    bus.data_i = 16'h0000;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_reset_outputs("reset");
    end
    rst = 1'b1;
    chk_reset_outputs("release_blank");
    step();

    prev = {GX, GX, GX, G0};
    check_frame("after_reset", prev, -1, 16'h0, -1, 16'h0);

    // Each word is loaded during digit 2 of the frame still showing the previous word.
    for (int i = 0; i < 7; i++) begin
      check_frame($sformatf("vec%0d", i), prev, 11, vecs[i].data, -1, 16'h0);
      prev = vecs[i].segs;
    end

    check_frame("last_wins_load", prev, 2, 16'h0005, 12, 16'h0009);
    prev = {GX, GX, GX, G9};
    check_frame("last_wins_show", prev, -1, 16'h0, -1, 16'h0);

    check_frame("boundary_load", prev, FRAME - 1, 16'h0042, -1, 16'h0);
    prev = {GX, GX, G4, G2};
    check_frame("boundary_show", prev, -1, 16'h0, -1, 16'h0);

    // Reset during digit 1 with a word pending; a load alongside reset is ignored.
    for (int i = 0; i < 6; i++) step();
    bus.load_i = 1'b1; bus.data_i = 16'h4321;
    step();
    bus.load_i = 1'b0;
    chk("midreset_pend_before", 16'(bus.pend_o), 16'h0001);
    step();
    rst = 1'b0; bus.load_i = 1'b1; bus.data_i = 16'h7777;
    step();
    bus.load_i = 1'b0;
    chk_reset_outputs("midreset");
    rst = 1'b1;
    chk_reset_outputs("midreset_blank");
    step();
    check_frame("midreset_show", {GX, GX, GX, G0}, -1, 16'h0, -1, 16'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
